// File: rtl/divisor_ctrl_pkg.sv
// divisor_ctrl_pkg: shared state encoding and constants for the keypad divider controller
package divisor_ctrl_pkg;
    typedef enum logic [2:0] {
        S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_START, S_WAIT, S_RESULT, S_ERR
    } state_t;
    localparam int TIMEOUT_DEFAULT = 1024;
    localparam logic [15:0] ERR_DISP = 16'hEEEE;
    function automatic logic [3:0] blank_of(input state_t s);
        return s == S_A_HI ? 4'b1111 :
               s == S_A_LO ? 4'b0111 :
               s == S_B_HI ? 4'b0011 :
               s == S_B_LO ? 4'b0001 : 4'b0000;
    endfunction
endpackage

// File: rtl/div_timeout_counter.sv
// div_timeout_counter: counts enabled cycles from 0 and flags the last allowed cycle
module div_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT) + 1;
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable)  count <= count + 1'b1;
    end
    assign expired = count == W'(LIMIT - 1);
endmodule

// File: rtl/divisor_seq_ctrl.sv
// divisor_seq_ctrl: collects two hex-keyed bytes, runs an external divider, displays the result
module divisor_seq_ctrl
    import divisor_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        div_start,
    output logic [7:0]  div_a,
    output logic [7:0]  div_b,
    input  logic        div_done,
    input  logic [7:0]  div_q,
    input  logic [7:0]  div_r,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_blank,
    output logic        busy,
    output logic        err
);
    state_t     state, state_n;
    logic [7:0] a, b, q, r, a_n, b_n, q_n, r_n;
    logic       expired;

    div_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != S_WAIT),
        .enable (state == S_WAIT),
        .expired(expired)
    );

    always_comb begin
        state_n = state;
        a_n = a;
        b_n = b;
        q_n = q;
        r_n = r;
        case (state)
            S_A_HI, S_RESULT, S_ERR: if (key_valid) begin
                a_n = {key_code, 4'h0};
                b_n = 8'h00;
                state_n = S_A_LO;
            end
            S_A_LO: if (key_valid) begin
                a_n[3:0] = key_code;
                state_n = S_B_HI;
            end
            S_B_HI: if (key_valid) begin
                b_n[7:4] = key_code;
                state_n = S_B_LO;
            end
            S_B_LO: if (key_valid) begin
                b_n[3:0] = key_code;
                state_n = b_n == 8'h00 ? S_ERR : S_START;
            end
            S_START: state_n = S_WAIT;
            S_WAIT: if (div_done) begin
                q_n = div_q;
                r_n = div_r;
                state_n = S_RESULT;
            end else if (expired) begin
                state_n = S_ERR;
            end
            default: state_n = S_A_HI;
        endcase
    end

    // Outputs are registered from next-state values so they track the current state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_A_HI;
            a <= '0;
            b <= '0;
            q <= '0;
            r <= '0;
            div_start <= 1'b0;
            div_a <= '0;
            div_b <= '0;
            disp_value <= '0;
            disp_blank <= 4'b1111;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            a <= a_n;
            b <= b_n;
            q <= q_n;
            r <= r_n;
            div_start <= state_n == S_START;
            div_a <= a_n;
            div_b <= b_n;
            disp_value <= state_n == S_ERR ? ERR_DISP : state_n == S_RESULT ? {q_n, r_n} : {a_n, b_n};
            disp_blank <= blank_of(state_n);
            busy <= state_n == S_START || state_n == S_WAIT;
            err <= state_n == S_ERR;
        end
    end
endmodule

// File: tb/tb_divisor_seq_ctrl.sv
// tb_divisor_seq_ctrl: directed vector table plus hand sequences for timeout, ignore and reset cases
module tb_divisor_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        div_start;
    logic [7:0]  div_a, div_b;
    logic        div_done = 1'b0;
    logic [7:0]  div_q = 8'h00, div_r = 8'h00;
    logic [15:0] disp_value;
    logic [3:0]  disp_blank;
    logic        busy, err;
    int          checks = 0, errors = 0, start_cnt = 0;

    typedef struct {
        logic [15:0] keys;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        exp_err;
        logic [15:0] exp_disp;
    } vec_t;
    vec_t vecs[6];

    divisor_seq_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .disp_value(disp_value), .disp_blank(disp_blank), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (div_start) start_cnt++;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code = k;
        step();
        key_valid = 1'b0;
    endtask

    task automatic done(input logic [7:0] q, input logic [7:0] r);
        div_done = 1'b1;
        div_q = q;
        div_r = r;
        step();
        div_done = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic enter_wait(input logic [15:0] keys);
        for (int k = 3; k >= 0; k--) key(keys[k*4 +: 4]);
        step();
    endtask

    initial begin
        vecs[0] = '{16'h4507, 8'h09, 8'h06, 1'b0, 16'h0906};
        vecs[1] = '{16'h1000, 8'h00, 8'h00, 1'b1, 16'hEEEE};
        vecs[2] = '{16'hFF01, 8'hFF, 8'h00, 1'b0, 16'hFF00};
        vecs[3] = '{16'hC803, 8'h42, 8'h02, 1'b0, 16'h4202};
        vecs[4] = '{16'h0000, 8'h00, 8'h00, 1'b1, 16'hEEEE};
        vecs[5] = '{16'h0A0B, 8'h00, 8'h0A, 1'b0, 16'h000A};

        step();
        step();
        rst = 1'b0;
        chk("reset disp", disp_value, 16'h0000);
        chk("reset blank", 16'(disp_blank), 16'hF);
        chk("reset busy", 16'(busy), 16'h0);
        chk("reset err", 16'(err), 16'h0);
        chk("reset start", 16'(div_start), 16'h0);

        key(4'hA);
        chk("entry1 blank", 16'(disp_blank), 16'h7);
        chk("entry1 disp", disp_value, 16'hA000);
        done(8'h55, 8'h55);
        chk("stray done disp", disp_value, 16'hA000);
        chk("stray done blank", 16'(disp_blank), 16'h7);
        key(4'hB);
        chk("entry2 blank", 16'(disp_blank), 16'h3);
        key(4'hC);
        chk("entry3 blank", 16'(disp_blank), 16'h1);
        chk("entry3 disp", disp_value, 16'hABC0);
        rst = 1'b1;
        step();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_cnt = 0;
            for (int k = 3; k >= 0; k--) begin
                key(vecs[i].keys[k*4 +: 4]);
                if (k == 3) begin
                    chk("first key blank", 16'(disp_blank), 16'h7);
                    chk("first key err", 16'(err), 16'h0);
                end
            end
            if (vecs[i].exp_err) begin
                chk("b0 err", 16'(err), 16'h1);
                chk("b0 disp", disp_value, vecs[i].exp_disp);
                chk("b0 busy", 16'(busy), 16'h0);
                step();
                chk("b0 no start", 16'(start_cnt), 16'h0);
            end else begin
                chk("start pulse", 16'(div_start), 16'h1);
                chk("start busy", 16'(busy), 16'h1);
                step();
                chk("wait start low", 16'(div_start), 16'h0);
                chk("div_a", 16'(div_a), 16'(vecs[i].keys[15:8]));
                chk("div_b", 16'(div_b), 16'(vecs[i].keys[7:0]));
                repeat (3) step();
                done(vecs[i].q, vecs[i].r);
                chk("result disp", disp_value, vecs[i].exp_disp);
                chk("result blank", 16'(disp_blank), 16'h0);
                chk("result busy", 16'(busy), 16'h0);
                chk("result err", 16'(err), 16'h0);
                chk("single start", 16'(start_cnt), 16'h1);
            end
        end

        enter_wait(16'h2003);
        repeat (15) step();
        chk("pre-timeout err", 16'(err), 16'h0);
        chk("pre-timeout busy", 16'(busy), 16'h1);
        step();
        chk("timeout err", 16'(err), 16'h1);
        chk("timeout disp", disp_value, 16'hEEEE);
        chk("timeout busy", 16'(busy), 16'h0);

        enter_wait(16'h2003);
        repeat (15) step();
        done(8'h0A, 8'h02);
        chk("late done err", 16'(err), 16'h0);
        chk("late done disp", disp_value, 16'h0A02);

        enter_wait(16'h6405);
        key(4'h1);
        step();
        key(4'h2);
        key_valid = 1'b1;
        key_code = 4'h3;
        done(8'h14, 8'h00);
        key_valid = 1'b0;
        chk("ignore key disp", disp_value, 16'h1400);
        chk("ignore key blank", 16'(disp_blank), 16'h0);
        chk("ignore key div_a", 16'(div_a), 16'h64);
        chk("ignore key div_b", 16'(div_b), 16'h05);
        chk("ignore key busy", 16'(busy), 16'h0);

        enter_wait(16'h9903);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        done(8'h77, 8'h11);
        chk("rst wait blank", 16'(disp_blank), 16'hF);
        chk("rst wait busy", 16'(busy), 16'h0);
        chk("rst wait disp", disp_value, 16'h0000);
        chk("rst wait err", 16'(err), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/divisor_seq_ctrl.md
DIVISOR_SEQ_CTRL -- requirements
Module: divisor_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, max cycles waited for div_done before error.
REQ-002 SHALL have ports:
  clk  in  1  single system clock.
  rst  in  1  synchronous, active-high reset.
  key_valid  in  1  one-cycle pulse, new keypad nibble.
  key_code  in  4  hex nibble 0x0..0xF, valid with key_valid.
  div_start  out  1  one-cycle start pulse to divider.
  div_a  out  8  dividend to divider.
  div_b  out  8  divisor to divider.
  div_done  in  1  divider completion pulse.
  div_q  in  8  quotient, valid with div_done.
  div_r  in  8  remainder, valid with div_done.
  disp_value  out  16  four hex digits to display driver, [15:12] leftmost.
  disp_blank  out  4  per-digit blank, bit3 = leftmost, 1 = blank.
  busy  out  1  high in S_START and S_WAIT.
  err  out  1  high in S_ERR.

Function
REQ-003 SHALL implement FSM states S_A_HI, S_A_LO, S_B_HI, S_B_LO, S_START, S_WAIT, S_RESULT, S_ERR.
REQ-004 SHALL, on key_valid in S_A_HI, load a[7:4]=key_code, clear a[3:0] and b, go S_A_LO next cycle.
REQ-005 SHALL, on key_valid in S_A_LO / S_B_HI / S_B_LO, load a[3:0] / b[7:4] / b[3:0] respectively and advance one state.
REQ-006 SHALL, on the S_B_LO key, go to S_ERR if the completed b equals 0x00, else S_START.
REQ-007 SHALL assert div_start for exactly the one cycle in S_START, then enter S_WAIT; divider is never started when b=0.
REQ-008 SHALL hold div_a=a, div_b=b stable from S_START until leaving S_WAIT.
REQ-009 SHALL, in S_WAIT, capture div_q/div_r on div_done and enter S_RESULT next cycle.
REQ-010 SHALL count cycles in S_WAIT from 0; reaching TIMEOUT_CYCLES-1 without div_done SHALL enter S_ERR.
REQ-011 SHALL give div_done priority over timeout when both occur in the same cycle.
REQ-012 SHALL ignore key_valid in S_START and S_WAIT, including when simultaneous with div_done.
REQ-013 SHALL ignore div_done outside S_WAIT.
REQ-014 SHALL, on key_valid in S_RESULT or S_ERR, behave as in S_A_HI (nibble becomes a[7:4], next state S_A_LO, err clears).
REQ-015 SHALL drive disp_value={a,b} in entry states, S_START, S_WAIT; {q,r} in S_RESULT; 16'hEEEE in S_ERR.
REQ-016 SHALL drive disp_blank: S_A_HI 4'b1111, S_A_LO 4'b0111, S_B_HI 4'b0011, S_B_LO 4'b0001, all other states 4'b0000.
REQ-017 SHALL register all outputs; each reflects the current state with no combinational path from inputs.

Reset
REQ-018 SHALL, when rst=1 at a clk edge, enter S_A_HI from any state, including mid-S_WAIT.
REQ-019 SHALL reset a, b, q, r, timeout counter to 0; div_start=0, busy=0, err=0, disp_value=0, disp_blank=4'b1111.
REQ-020 SHALL ignore a div_done arriving after a reset that interrupted S_WAIT.

Structure
REQ-021 SHALL place the state enum, TIMEOUT_CYCLES default and error display constant 16'hEEEE in package divisor_ctrl_pkg.
REQ-022 SHALL implement the S_WAIT counter as sub-module div_timeout_counter (clear, enable, expired output).

Verification
REQ-023 Keys 4,5,0,7; divider returns q=9, r=6 -> single div_start, div_a=0x45, div_b=0x07, disp_value=0x0906, blank=0000.
REQ-024 Keys 1,0,0,0 -> S_ERR one cycle after last key, err=1, disp_value=0xEEEE, div_start never asserted.
REQ-025 Keys F,F,0,1; divider returns q=255, r=0 -> disp_value=0xFF00.
REQ-026 Valid operands, div_done held low, TIMEOUT_CYCLES=16 -> err=1 exactly 16 cycles after entering S_WAIT; div_done on that 16th cycle -> S_RESULT instead.
REQ-027 key_valid pulses during S_WAIT, one coincident with div_done -> operands and result unchanged, state S_RESULT.
REQ-028 rst mid-S_WAIT, then late div_done -> S_A_HI, blank=1111, busy=0, no result captured.
